// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// glyph codes, active-low segment patterns ({g,f,e,d,c,b,a}) and scan FSM types.
package seg_pkg;

    // Brightness is a 3-bit duty level (0..7), on for (bright+1)/8 of a slot.
    localparam int BRIGHT_W = 3;

    // Non-numeric glyph codes.
    localparam logic [3:0] GLY_BLANK = 4'd10;
    localparam logic [3:0] GLY_DASH  = 4'd11;
    localparam logic [3:0] GLY_A     = 4'd12;
    localparam logic [3:0] GLY_P     = 4'd13;
    localparam logic [3:0] GLY_E     = 4'd14;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0011000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_P    = 7'b0001100;
    localparam logic [6:0] SEG_E    = 7'b0000110;

    // One pattern per 4-bit glyph code; codes 10 and 15 are both blank.
    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_OFF, SEG_DASH, SEG_A, SEG_P, SEG_E, SEG_OFF
    };

    // Scan FSM: one load state right after reset, then continuous scanning.
    typedef enum logic {
        ST_LOAD,
        ST_SCAN
    } scan_state_t;

    // Per-slot snapshot of the inputs belonging to the digit being shown.
    typedef struct packed {
        logic [3:0] glyph;
        logic       blank;
        logic       blink;
        logic       dp;
    } slot_cfg_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the timekeeping/settings logic (master) and the scan driver (slave):
// glyph/mask/brightness/enable inputs and the registered anode/segment pin drive.
interface seg_scan_driver_if
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic [4*DIGITS-1:0] glyphs;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic [DIGITS-1:0]   dp_mask;
    logic [BRIGHT_W-1:0] bright;
    logic                enable;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;

    // Display-content producer.
    modport master (
        output glyphs, blank_mask, blink_mask, dp_mask, bright, enable,
        input  an, seg, dp
    );

    // Scan driver.
    modport slave (
        input  glyphs, blank_mask, blink_mask, dp_mask, bright, enable,
        output an, seg, dp
    );

endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: 4-bit glyph code to active-low {g,f,e,d,c,b,a}.
// Every code has a pattern, so the decode is full-case by construction.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] glyph,
    output logic [6:0] seg
);

    // Table lookup covers all 16 codes.
    assign seg = SEG_TABLE[glyph];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver.
// Scans DIGITS digits left to right, SCAN_CYCLES clocks per digit, with per-digit
// blank/blink/dp masks, 8-level PWM brightness and a global enable.
// Optional build macro SEG_LZB_EN enables leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_CYCLES  = 100000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOT_W  = $clog2(SCAN_CYCLES);
    localparam int STEP    = SCAN_CYCLES / 8;
    localparam int DIV_W   = $clog2(STEP);
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(STEP - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LEFT  = IDX_W'(DIGITS - 1);

    scan_state_t          state;
    logic [SLOT_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic [DIV_W-1:0]     pwm_div;
    logic [BRIGHT_W-1:0]  pwm_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_ph;
    slot_cfg_t            cfg_s;
    slot_cfg_t            cfg_next;
    logic                 slot_wrap;
    logic                 pwm_on;
    logic                 lit;
    logic [6:0]           seg_dec;
    logic [DIGITS-1:0]    an_q;
    logic [6:0]           seg_q;
    logic                 dp_q;

`ifdef SEG_LZB_EN
    logic                 zero_run;
    logic [DIGITS-1:0]    lead_zero;
`endif

    // Slot boundary and the digit index that the next slot will show.
    assign slot_wrap = (slot_cnt == SLOT_MAX);
    assign idx_next  = !slot_wrap ? idx :
                       (idx == '0) ? IDX_LEFT : idx - IDX_W'(1);

    // Anode gating: blank beats blink, both beat PWM-on and enable.
    assign pwm_on = (pwm_cnt <= bus.bright);
    assign lit    = bus.enable & pwm_on & ~cfg_s.blank & ~(cfg_s.blink & blink_ph);

    // Snapshot of the inputs for the digit that the next slot will show.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        cfg_next       = '0;
        cfg_next.glyph = bus.glyphs[{idx_next, 2'b00} +: 4];
        cfg_next.blank = bus.blank_mask[idx_next];
        cfg_next.blink = bus.blink_mask[idx_next];
        cfg_next.dp    = bus.dp_mask[idx_next];
`ifdef SEG_LZB_EN
        // A zero is a leading zero when it and every digit to its left are zero;
        // digit 0 is never part of the run, so a lone "0" still shows.
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (bus.glyphs[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
        if (lead_zero[idx_next]) begin
            cfg_next.glyph = GLY_BLANK;
        end
`endif
    end

    // Slot, PWM and blink timers; all free-running once out of reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            slot_cnt  <= '0;
            idx       <= IDX_LEFT;
            pwm_div   <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            idx <= idx_next;
            if (slot_wrap) begin
                slot_cnt <= '0;
                pwm_div  <= '0;
                pwm_cnt  <= '0;
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
                if (pwm_div == DIV_MAX) begin
                    pwm_div <= '0;
                    pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
                end else begin
                    pwm_div <= pwm_div + DIV_W'(1);
                end
            end
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Scan FSM: sample the first slot right after reset, then at every slot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
            // NOTE: the sampled snapshot is reset to a blanked digit so the anode stays dark until the first real sample.
            cfg_s <= '{glyph: GLY_BLANK, blank: 1'b1, blink: 1'b0, dp: 1'b0};
        end else begin
            case (state)
                ST_LOAD: begin
                    cfg_s <= cfg_next;
                    state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (slot_wrap) begin
                        cfg_s <= cfg_next;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    seg_glyph_decode u_decode (
        .glyph (cfg_s.glyph),
        .seg   (seg_dec)
    );

    // Registered pin drive: one-hot-low anode, segments one cycle after sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= lit ? ~(DIGITS'(1) << idx) : '1;
            seg_q <= seg_dec;
            dp_q  <= lit ? ~cfg_s.dp : 1'b1;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGITS=4, SCAN_CYCLES=16,
// BLINK_CYCLES=100). cyc counts rising edges since the last reset edge; outputs
// are sampled 1 time unit after each edge. Build with SEG_LZB_EN for the blanking variant.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int SCAN   = 16;
    localparam int BLINK  = 100;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S9    = 7'b0011000;
    localparam logic [6:0] SOFF  = 7'h7F;
    localparam logic [6:0] SDASH = 7'b0111111;
    localparam logic [6:0] SA    = 7'b0001000;
    localparam logic [6:0] SP    = 7'b0001100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_CYCLES  (SCAN),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    // Digit shown in the slot containing edge k (slot s spans edges 16s+1..16s+16).
    function automatic int digit_at(input int k);
        return 3 - (((k - 1) / SCAN) % 4);
    endfunction

    task automatic test_reset();
        bus.glyphs     = 16'h1234;
        bus.blank_mask = '0;
        bus.blink_mask = '0;
        bus.dp_mask    = '0;
        bus.bright     = 3'd7;
        bus.enable     = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (bus.an !== 4'b1111) begin
                errors++; $display("FAIL reset_an got=%b exp=1111", bus.an);
            end
            checks++;
            if (bus.seg !== SOFF) begin
                errors++; $display("FAIL reset_seg got=%b exp=%b", bus.seg, SOFF);
            end
            checks++;
            if (bus.dp !== 1'b1) begin
                errors++; $display("FAIL reset_dp got=%b exp=1", bus.dp);
            end
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_scan_order();
        int d;
        logic [3:0] ea;
        logic [6:0] es;
        tick();
        checks++;
        if (bus.an !== 4'b1111) begin
            errors++; $display("FAIL scan_first_cycle_an k=%0d got=%b exp=1111", cyc, bus.an);
        end
        for (int k = 2; k <= 80; k++) begin
            tick();
            d  = digit_at(cyc);
            ea = ~(4'b0001 << d);
            case (d)
                3:       es = S1;
                2:       es = S2;
                1:       es = S3;
                default: es = S4;
            endcase
            checks++;
            if (bus.an !== ea) begin
                errors++; $display("FAIL scan_an k=%0d got=%b exp=%b", cyc, bus.an, ea);
            end
            checks++;
            if (bus.seg !== es) begin
                errors++; $display("FAIL scan_seg k=%0d got=%b exp=%b", cyc, bus.seg, es);
            end
            checks++;
            if (bus.dp !== 1'b1) begin
                errors++; $display("FAIL scan_dp k=%0d got=%b exp=1", cyc, bus.dp);
            end
        end
    endtask

    task automatic test_mid_slot_change();
        run_to(128);
        for (int k = 129; k <= 144; k++) begin
            tick();
            checks++;
            if (bus.an !== 4'b0111 || bus.seg !== S1) begin
                errors++; $display("FAIL mid_slot_hold k=%0d an=%b seg=%b exp an=0111 seg=%b", cyc, bus.an, bus.seg, S1);
            end
            if (cyc == 133) bus.glyphs = 16'h9234;
        end
        run_to(192);
        for (int k = 193; k <= 208; k++) begin
            tick();
            checks++;
            if (bus.an !== 4'b0111 || bus.seg !== S9) begin
                errors++; $display("FAIL mid_slot_next_visit k=%0d an=%b seg=%b exp an=0111 seg=%b", cyc, bus.an, bus.seg, S9);
            end
        end
    endtask

    task automatic test_brightness();
        logic [3:0] ea;
        run_to(208);
        bus.bright = 3'd1;
        for (int k = 209; k <= 224; k++) begin
            tick();
            ea = (cyc - 208 <= 4) ? 4'b1011 : 4'b1111;
            checks++;
            if (bus.an !== ea) begin
                errors++; $display("FAIL bright1_an k=%0d got=%b exp=%b", cyc, bus.an, ea);
            end
            checks++;
            if (bus.seg !== S2) begin
                errors++; $display("FAIL bright1_seg k=%0d got=%b exp=%b", cyc, bus.seg, S2);
            end
        end
        bus.bright = 3'd0;
        for (int k = 225; k <= 240; k++) begin
            tick();
            ea = (cyc - 224 <= 2) ? 4'b1101 : 4'b1111;
            checks++;
            if (bus.an !== ea) begin
                errors++; $display("FAIL bright0_an k=%0d got=%b exp=%b", cyc, bus.an, ea);
            end
        end
        bus.bright = 3'd7;
    endtask

    task automatic test_blink_blank();
        int d;
        int ph;
        logic [3:0] ea;
        logic       ed;
        bus.blink_mask = 4'b0011;
        bus.blank_mask = 4'b0001;
        bus.dp_mask    = 4'b0011;
        run_to(256);
        for (int k = 257; k <= 432; k++) begin
            tick();
            d  = digit_at(cyc);
            ph = ((cyc - 1) / BLINK) % 2;
            if (d == 0 || (d == 1 && ph == 1)) begin
                ea = 4'b1111; ed = 1'b1;
            end else if (d == 1) begin
                ea = 4'b1101; ed = 1'b0;
            end else begin
                ea = ~(4'b0001 << d); ed = 1'b1;
            end
            checks++;
            if (bus.an !== ea) begin
                errors++; $display("FAIL blink_blank_an k=%0d got=%b exp=%b", cyc, bus.an, ea);
            end
            checks++;
            if (bus.dp !== ed) begin
                errors++; $display("FAIL blink_blank_dp k=%0d got=%b exp=%b", cyc, bus.dp, ed);
            end
        end
    endtask

    task automatic test_glyphs_enable();
        int d;
        logic [6:0] es;
        bus.glyphs     = 16'hABCD;
        bus.blink_mask = '0;
        bus.blank_mask = '0;
        bus.dp_mask    = '0;
        run_to(448);
        for (int k = 449; k <= 512; k++) begin
            tick();
            d = digit_at(cyc);
            case (d)
                3:       es = SOFF;
                2:       es = SDASH;
                1:       es = SA;
                default: es = SP;
            endcase
            checks++;
            if (bus.seg !== es) begin
                errors++; $display("FAIL glyph_seg k=%0d got=%b exp=%b", cyc, bus.seg, es);
            end
            checks++;
            if (bus.an !== ~(4'b0001 << d)) begin
                errors++; $display("FAIL glyph_an k=%0d got=%b digit=%0d", cyc, bus.an, d);
            end
        end
        run_to(520);
        checks++;
        if (bus.an !== 4'b0111) begin
            errors++; $display("FAIL enable_before k=%0d got=%b exp=0111", cyc, bus.an);
        end
        bus.enable = 1'b0;
        for (int k = 521; k <= 540; k++) begin
            tick();
            checks++;
            if (bus.an !== 4'b1111 || bus.dp !== 1'b1) begin
                errors++; $display("FAIL enable_off k=%0d an=%b dp=%b exp an=1111 dp=1", cyc, bus.an, bus.dp);
            end
        end
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.an !== 4'b1011) begin
            errors++; $display("FAIL enable_on k=%0d got=%b exp=1011", cyc, bus.an);
        end
    endtask

    task automatic test_reset_mid_slot_lzb();
        int d;
        logic [6:0] es;
        rst = 1'b1;
        bus.glyphs = 16'h0005;
        tick();
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== SOFF || bus.dp !== 1'b1) begin
            errors++; $display("FAIL mid_reset an=%b seg=%b dp=%b exp 1111/%b/1", bus.an, bus.seg, bus.dp, SOFF);
        end
        rst = 1'b0;
        cyc = 0;
        tick();
        checks++;
        if (bus.an !== 4'b1111) begin
            errors++; $display("FAIL restart_first_cycle got=%b exp=1111", bus.an);
        end
        for (int k = 2; k <= 128; k++) begin
            tick();
            d = digit_at(cyc);
`ifdef SEG_LZB_EN
            if (d != 0)         es = SOFF;
            else if (cyc <= 64) es = S5;
            else                es = S0;
`else
            if (d != 0)         es = S0;
            else if (cyc <= 64) es = S5;
            else                es = S0;
`endif
            checks++;
            if (bus.an !== ~(4'b0001 << d)) begin
                errors++; $display("FAIL lzb_an k=%0d got=%b digit=%0d", cyc, bus.an, d);
            end
            checks++;
            if (bus.seg !== es) begin
                errors++; $display("FAIL lzb_seg k=%0d got=%b exp=%b", cyc, bus.seg, es);
            end
            if (cyc == 64) bus.glyphs = 16'h0000;
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_mid_slot_change();
        test_brightness();
        test_blink_blank();
        test_glyphs_enable();
        test_reset_mid_slot_lzb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at k=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed 7-segment display driver and the next generation of the fixed 4-digit clock display.
- Scans DIGITS common-anode digits (anodes active-low, segments active-low) from a packed 4-bit glyph bus.
- Adds a per-digit blank mask, a per-digit blink mask, a per-digit decimal-point mask, PWM brightness and a global enable.
- Sits between the timekeeping/settings logic and the board pins.

Parameters:
- DIGITS, 4: number of digits scanned; ≥1.
- SCAN_CYCLES, 100000: clk cycles per digit slot. Must be a multiple of 8 and ≥16.
- BLINK_CYCLES, 25000000: clk cycles per blink half-period.
- BRIGHT_W, 3: fixed at 3; brightness levels 0..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- glyphs  in  4*DIGITS  glyph code per digit. Digit i is glyphs[4i+3:4i]; digit DIGITS-1 is leftmost.
- blank_mask  in  DIGITS  1 = digit forced dark.
- blink_mask  in  DIGITS  1 = digit dark during the blink-off phase.
- dp_mask  in  DIGITS  1 = decimal point lit on that digit.
- bright  in  3  duty level; anode on for (bright+1)/8 of each slot.
- enable  in  1  0 = all anodes off; counters keep running.
- an  out  DIGITS  anode drive, active-low, registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - slot_cnt=0, idx=DIGITS-1, pwm_cnt=0, blink_cnt=0, blink_ph=0.
  - an=all 1s, seg=7'h7F, dp=1.
  - Reset asserted mid-slot takes effect on that edge; the scan restarts at the leftmost digit after release.
- Slot counter:
  - slot_cnt counts 0..SCAN_CYCLES-1, then wraps to 0.
  - On wrap, idx decrements; idx=0 wraps to DIGITS-1.
  - Scan order is left to right. Every digit gets exactly SCAN_CYCLES cycles.
- Input sampling:
  - glyph, blank, blink and dp state for the new idx are sampled on the wrap edge and held for the whole slot. Input changes mid-slot have no effect until the next slot.
  - seg and dp are updated on the cycle after the wrap (1-cycle latency).
  - The first slot after reset samples on the cycle after reset release.
- Glyph map:
  - 0..9 are decimal digits, using the existing seg codes (0=7'b1000000 … 9=7'b0011000).
  - 10 = blank (7'h7F), 11 = '-' (7'b0111111), 12 = 'A' (7'b0001000), 13 = 'P' (7'b0001100), 14 = 'E' (7'b0000110), 15 = blank.
  - There is no undefined code; decode is full-case.
- PWM:
  - pwm_cnt increments every SCAN_CYCLES/8 clk cycles, from 0 to 7.
  - It is reset to 0 at each slot wrap.
  - pwm_on = (pwm_cnt <= bright).
  - bright is sampled every cycle, so a change applies within the current slot.
- Anode:
  - an is registered every cycle: one-hot-low at idx when enable & pwm_on & ~blank_s & ~(blink_s & blink_ph); otherwise all 1s.
  - enable and blink_ph are sampled every cycle.
- Blink:
  - blink_cnt counts 0..BLINK_CYCLES-1; on wrap blink_ph toggles.
  - The blink timer is free-running and independent of slot timing.
- dp output: dp = ~dp_s when the anode is on, else 1.
- Simultaneous masks: blank beats blink beats dp. A blanked digit shows no dp.
- DIGITS=1: idx stays 0 and the anode stays on digit 0; timing is otherwise unchanged.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- When defined:
  - A glyph of 0 on digit i is shown as blank if every digit above i is also 0.
  - Digit 0 is never blanked by this rule.
  - The rule is evaluated on the sampled glyph bus at the slot wrap.
  - Example: hour 05 displays " 5".
- When undefined: zeros are always displayed, and the block is identical to the baseline behaviour above.

Decomposition:
- Package seg_pkg holds:
  - glyph code constants: GLY_BLANK=10, GLY_DASH=11, GLY_A=12, GLY_P=13, GLY_E=14;
  - the 16-entry segment pattern constants;
  - SEG_OFF=7'h7F.
- One combinational sub-module, seg_glyph_decode: 4-bit glyph in, 7-bit seg out.
- All counters and the scan state machine stay in seg_scan_driver.

Test Plan:
- Bench parameters: DIGITS=4, SCAN_CYCLES=16, BLINK_CYCLES=100.
- Reset and scan order:
  - Stimulus: hold rst 3 cycles, glyphs=16'h1234, bright=7, masks=0, enable=1.
  - Response: an=4'b1111 and seg=7'h7F during reset.
  - Then an sequence 0111, 1011, 1101, 1110, 0111 with 16 cycles each; seg shows 1, 2, 3, 4 in turn.
- Mid-slot input change:
  - Stimulus: change glyphs from 16'h1234 to 16'h9234 at cycle 5 of digit-3's slot.
  - Response: seg stays '1' for the rest of that slot; '9' appears on the next visit to digit 3.
- Brightness:
  - Stimulus: bright=1.
  - Response: per slot, the anode is low for exactly 4 cycles (pwm_cnt 0..1), then high for 12.
  - Stimulus: bright=0. Response: low for 2 cycles.
- Blink and blank priority:
  - Stimulus: blink_mask=4'b0011, blank_mask=4'b0001, dp_mask=4'b0011.
  - Response: digit 0 is always dark with dp=1.
  - Digit 1 is lit with dp=0 while blink_ph=0, and dark while blink_ph=1; blink_ph toggles every 100 cycles.
- Glyphs and enable:
  - Stimulus: glyphs=16'hABCD.
  - Response: seg shows 7'h7F, 7'b0111111, 7'b0001000, 7'b0001100.
  - Stimulus: enable=0. Response: an=4'b1111 from the next cycle.
- SEG_LZB_EN build:
  - Stimulus: glyphs=16'h0005.
  - Response: digits 3..1 are dark (seg=7'h7F) and digit 0 shows '5'.
  - Stimulus: glyphs=16'h0000. Response: only digit 0 shows '0'.
